// File: rtl/mem_pkg.sv
// Shared definitions for the mem_handle protocol and its memory-side responder.
//   CACHE_SIZE / CACHE_BITS : posted-write buffer depth and its index width
//   ADDR_SIZE / DATA_SIZE   : handle address and data widths
//   M9K_SIZE                : words in one M9K-backed RAM
//   wbuf_entry_t            : one posted write {addr, data}
//   resp_state_e            : responder FSM states
package mem_pkg;

  localparam int unsigned CACHE_SIZE = 8;
  localparam int unsigned CACHE_BITS = $clog2(CACHE_SIZE);
  localparam int unsigned ADDR_SIZE  = 32;
  localparam int unsigned DATA_SIZE  = 32;
  localparam int unsigned M9K_SIZE   = 1024;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdAddr,
    StRdData,
    StFlush
  } resp_state_e;

endpackage

// File: rtl/m9k_ram.sv
// Single-port RAM with registered read, no reset; written so it maps onto M9K blocks.
//   clk_i   : clock
//   we_i    : write enable for addr_i/wdata_i
//   addr_i  : word address (read and write share it)
//   wdata_i : write data
//   rdata_o : data at the address presented in the previous cycle (old data on a same-cycle write)
module m9k_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_handle_responder.sv
// Memory-side end of a mem_handle: services single-word reads/writes from one RAM plus a
// posted-write buffer that drains to RAM in FIFO order whenever the handle is idle.
// The mem_handle bundle is carried as flat hdl_* signals:
//   hdl_region_begin/end : window the requester may touch, [begin, end)
//   hdl_ptr              : request address
//   hdl_w_en / hdl_r_en  : request strobes (write wins when both are set)
//   hdl_write_through    : write goes straight to RAM after draining the buffer
//   hdl_read_through     : read comes from RAM after draining the buffer
//   hdl_data_store       : write data
//   hdl_avail            : responder can accept a request on the next edge
//   hdl_done             : one-cycle completion pulse
//   hdl_data_load        : read data, valid with done, held until the next done
// Other ports:
//   clock, reset_n       : clock and asynchronous active-low reset
//   err                  : pulses with done when the request was rejected
//   pending              : posted-write buffer occupancy
module mem_handle_responder
  import mem_pkg::*;
#(
  parameter int unsigned          DEPTH     = M9K_SIZE,
  parameter logic [ADDR_SIZE-1:0] BASE      = '0,
  parameter int unsigned          BUF_DEPTH = CACHE_SIZE
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [ADDR_SIZE-1:0]       hdl_region_begin,
  input  logic [ADDR_SIZE-1:0]       hdl_region_end,
  input  logic [ADDR_SIZE-1:0]       hdl_ptr,
  input  logic                       hdl_w_en,
  input  logic                       hdl_r_en,
  input  logic                       hdl_write_through,
  input  logic                       hdl_read_through,
  input  logic [DATA_SIZE-1:0]       hdl_data_store,
  output logic                       hdl_avail,
  output logic                       hdl_done,
  output logic [DATA_SIZE-1:0]       hdl_data_load,
  output logic                       err,
  output logic [$clog2(BUF_DEPTH):0] pending
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(BUF_DEPTH);

  typedef logic [BW:0] cnt_t;

  function automatic logic [AW-1:0] ram_index(input logic [ADDR_SIZE-1:0] a);
    return AW'(a - BASE);
  endfunction

  resp_state_e          state_q, state_d;
  logic                 avail_q, avail_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [DATA_SIZE-1:0] data_load_q, data_load_d;

  // Request captured at the sampling edge.
  logic [ADDR_SIZE-1:0] req_addr_q, req_addr_d;
  logic [DATA_SIZE-1:0] req_data_q, req_data_d;
  logic                 req_write_q, req_write_d;
  logic                 req_wt_q, req_wt_d;
  logic                 req_err_q, req_err_d;
  logic                 req_fwd_q, req_fwd_d;
  logic                 req_flush_all_q, req_flush_all_d;

  // Posted-write buffer.
  wbuf_entry_t          wbuf_q [BUF_DEPTH];
  logic [BW-1:0]        head_q, head_d, tail_q, tail_d;
  cnt_t                 count_q, count_d;
  logic                 push, pop;
  logic                 buf_empty, buf_full;

  logic                 ram_we;
  logic [AW-1:0]        ram_addr;
  logic [DATA_SIZE-1:0] ram_wdata, ram_rdata;

  logic [ADDR_SIZE-1:0] lookup_addr;
  logic                 hit;
  logic [DATA_SIZE-1:0] hit_data;

  logic [ADDR_SIZE:0]   offset;
  logic                 in_region, in_ram, legal, req_valid;

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == cnt_t'(BUF_DEPTH));
  assign req_valid = hdl_r_en | hdl_w_en;

  // Range check on the live request; the extra MSB of offset is the borrow for ptr < BASE.
  always_comb begin
    offset    = {1'b0, hdl_ptr} - {1'b0, BASE};
    in_region = (hdl_ptr >= hdl_region_begin) && (hdl_ptr < hdl_region_end);
    in_ram    = !offset[ADDR_SIZE] && (offset[ADDR_SIZE-1:0] < ADDR_SIZE'(DEPTH));
    legal     = in_region && in_ram;
  end

  // Parallel compare over live entries, oldest to youngest, so the youngest match wins.
  // In IDLE the live ptr is looked up to steer the request; afterwards the captured one.
  always_comb begin
    lookup_addr = (state_q == StIdle) ? hdl_ptr : req_addr_q;
    hit         = 1'b0;
    hit_data    = '0;
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      if ((cnt_t'(i) < count_q) && (wbuf_q[head_q + BW'(i)].addr == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = wbuf_q[head_q + BW'(i)].data;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    avail_d         = avail_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    data_load_d     = data_load_q;
    req_addr_d      = req_addr_q;
    req_data_d      = req_data_q;
    req_write_d     = req_write_q;
    req_wt_d        = req_wt_q;
    req_err_d       = req_err_q;
    req_fwd_d       = req_fwd_q;
    req_flush_all_d = req_flush_all_q;
    push            = 1'b0;
    pop             = 1'b0;
    // The RAM port defaults to retiring the oldest buffer entry.
    ram_we          = 1'b0;
    ram_addr        = ram_index(wbuf_q[head_q].addr);
    ram_wdata       = wbuf_q[head_q].data;

    unique case (state_q)
      StIdle: begin
        if (avail_q && req_valid) begin
          avail_d         = 1'b0;
          req_addr_d      = hdl_ptr;
          req_data_d      = hdl_data_store;
          req_write_d     = hdl_w_en;
          req_wt_d        = hdl_write_through;
          req_err_d       = !legal;
          req_fwd_d       = 1'b0;
          req_flush_all_d = 1'b1;
          if (!legal) begin
            // Rejections reuse the single-cycle WR slot with no side effects.
            state_d = StWr;
          end else if (hdl_w_en) begin
            if (hdl_write_through) begin
              state_d = buf_empty ? StWr : StFlush;
            end else if (buf_full) begin
              req_flush_all_d = 1'b0;
              state_d         = StFlush;
            end else begin
              state_d = StWr;
            end
          end else if (hdl_read_through) begin
            state_d = buf_empty ? StRdAddr : StFlush;
          end else if (hit) begin
            req_fwd_d = 1'b1;
            state_d   = StRdData;
          end else begin
            state_d = StRdAddr;
          end
        end else begin
          // avail rises one cycle after done; background drain only while avail is up.
          avail_d = 1'b1;
          if (avail_q && !buf_empty) begin
            pop    = 1'b1;
            ram_we = 1'b1;
          end
        end
      end

      StFlush: begin
        pop    = 1'b1;
        ram_we = 1'b1;
        if (!req_flush_all_q || (count_q == cnt_t'(1))) begin
          state_d = req_write_q ? StWr : StRdAddr;
        end
      end

      StWr: begin
        done_d      = 1'b1;
        data_load_d = '0;
        state_d     = StIdle;
        if (req_err_q) begin
          err_d = 1'b1;
        end else if (req_wt_q) begin
          ram_we    = 1'b1;
          ram_addr  = ram_index(req_addr_q);
          ram_wdata = req_data_q;
        end else begin
          push = 1'b1;
        end
      end

      StRdAddr: begin
        ram_addr = ram_index(req_addr_q);
        state_d  = StRdData;
      end

      StRdData: begin
        done_d      = 1'b1;
        data_load_d = req_fwd_q ? hit_data : ram_rdata;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d  = head_q + BW'(1);
      count_d = count_q - cnt_t'(1);
    end
    if (push) begin
      tail_d  = tail_q + BW'(1);
      count_d = count_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      avail_q         <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      data_load_q     <= '0;
      req_addr_q      <= '0;
      req_data_q      <= '0;
      req_write_q     <= 1'b0;
      req_wt_q        <= 1'b0;
      req_err_q       <= 1'b0;
      req_fwd_q       <= 1'b0;
      req_flush_all_q <= 1'b0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      avail_q         <= avail_d;
      done_q          <= done_d;
      err_q           <= err_d;
      data_load_q     <= data_load_d;
      req_addr_q      <= req_addr_d;
      req_data_q      <= req_data_d;
      req_write_q     <= req_write_d;
      req_wt_q        <= req_wt_d;
      req_err_q       <= req_err_d;
      req_fwd_q       <= req_fwd_d;
      req_flush_all_q <= req_flush_all_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
    end
  end

  // Entry storage needs no reset: only slots inside [head, head+count) are ever read.
  always_ff @(posedge clock) begin
    if (push) begin
      wbuf_q[tail_q] <= '{addr: req_addr_q, data: req_data_q};
    end
  end

  m9k_ram #(
    .Depth (DEPTH),
    .Width (DATA_SIZE)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign hdl_avail     = avail_q;
  assign hdl_done      = done_q;
  assign hdl_data_load = data_load_q;
  assign err           = err_q;
  assign pending       = count_q;

endmodule

// File: tb/tb_mem_handle_responder.sv
module tb_mem_handle_responder;
  import mem_pkg::*;

  localparam int unsigned Depth  = 1024;
  localparam int unsigned BufMax = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] rb = '0, re = '0, ptr = '0, data_store = '0;
  logic        w_en = 1'b0, r_en = 1'b0, write_through = 1'b0, read_through = 1'b0;
  logic        avail, done, err;
  logic [31:0] data_load;
  logic [3:0]  pending;

  always #5 clock = ~clock;

  mem_handle_responder #(
    .DEPTH     (Depth),
    .BASE      (32'h0),
    .BUF_DEPTH (BufMax)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .hdl_region_begin  (rb),
    .hdl_region_end    (re),
    .hdl_ptr           (ptr),
    .hdl_w_en          (w_en),
    .hdl_r_en          (r_en),
    .hdl_write_through (write_through),
    .hdl_read_through  (read_through),
    .hdl_data_store    (data_store),
    .hdl_avail         (avail),
    .hdl_done          (done),
    .hdl_data_load     (data_load),
    .err               (err),
    .pending           (pending)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: RAM image with a written-flag, and the posted writes as a FIFO queue.
  logic [31:0] mem_model [Depth];
  bit          mem_valid [Depth];
  wbuf_entry_t wq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic retire_one();
    wbuf_entry_t e;
    e = wq.pop_front();
    mem_model[e.addr[9:0]] = e.data;
    mem_valid[e.addr[9:0]] = 1'b1;
  endtask

  task automatic drain_all();
    while (wq.size() > 0) retire_one();
  endtask

  // n cycles with no request; each cycle the responder is available retires one posted write.
  task automatic idle(input int n);
    bit a;
    w_en = 1'b0;
    r_en = 1'b0;
    for (int c = 0; c < n; c++) begin
      a = avail;
      @(posedge clock);
      #1;
      if (a && wq.size() > 0) retire_one();
    end
  endtask

  task automatic transact(input string tag, input bit wr, input bit both, input logic [31:0] p,
                          input logic [31:0] d, input bit thr);
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_data;
    bit          chk_data;
    int          lat;
    int          guard;
    bit          found;

    exp_err  = !((p >= rb) && (p < re) && (p < Depth));
    exp_data = '0;
    chk_data = 1'b1;
    if (exp_err) begin
      exp_lat = 1;
    end else if (wr) begin
      chk_data = 1'b0;
      if (thr) begin
        exp_lat = wq.size() + 1;
        drain_all();
        mem_model[p[9:0]] = d;
        mem_valid[p[9:0]] = 1'b1;
      end else begin
        exp_lat = 1;
        if (wq.size() == BufMax) begin
          exp_lat = 2;
          retire_one();
        end
        wq.push_back('{addr: p, data: d});
      end
    end else if (thr) begin
      exp_lat = wq.size() + 2;
      drain_all();
      exp_data = mem_model[p[9:0]];
      chk_data = mem_valid[p[9:0]];
    end else begin
      found = 1'b0;
      for (int i = wq.size() - 1; i >= 0; i--) begin
        if (!found && wq[i].addr == p) begin
          found    = 1'b1;
          exp_data = wq[i].data;
        end
      end
      if (found) begin
        exp_lat = 1;
      end else begin
        exp_lat  = 2;
        exp_data = mem_model[p[9:0]];
        chk_data = mem_valid[p[9:0]];
      end
    end

    ptr           = p;
    data_store    = d;
    w_en          = wr;
    r_en          = !wr || both;
    write_through = wr ? thr : 1'($urandom_range(0, 1));
    read_through  = wr ? 1'($urandom_range(0, 1)) : thr;

    guard = 0;
    while (avail !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) begin
      check({tag, ".avail_timeout"}, {31'b0, avail}, 32'd1);
      w_en = 1'b0;
      r_en = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
    lat  = 0;
    while (lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (done === 1'b1) break;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, ".pending"}, {28'b0, pending}, wq.size());
    check({tag, ".avail_low"}, {31'b0, avail}, 32'd0);
    if (chk_data) check({tag, ".data"}, data_load, exp_data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;

    // Reset state, asynchronous.
    #2 reset_n = 1'b0;
    #1;
    check("rst.avail", {31'b0, avail}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.err", {31'b0, err}, 32'd0);
    check("rst.data", data_load, 32'd0);
    check("rst.pending", {28'b0, pending}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst.avail_rise", {31'b0, avail}, 32'd1);

    rb = 32'd0;
    re = 32'd1024;

    // Write-through on an empty buffer, then a RAM read back.
    transact("wt5", 1'b1, 1'b0, 32'd5, 32'hDEADBEEF, 1'b1);
    transact("rd5", 1'b0, 1'b0, 32'd5, $urandom, 1'b0);

    // Forwarding of the youngest duplicate.
    transact("pw7a", 1'b1, 1'b0, 32'd7, 32'h11, 1'b0);
    transact("pw7b", 1'b1, 1'b0, 32'd7, 32'h22, 1'b0);
    transact("fwd7", 1'b0, 1'b0, 32'd7, $urandom, 1'b0);
    idle(4);

    // Fill the buffer, overflow by one, drain, read everything back from RAM.
    for (int i = 0; i < 9; i++) begin
      transact("fill", 1'b1, 1'b0, 32'(i), 32'hA000 + 32'(i), 1'b0);
    end
    idle(9);
    check("drain.pending", {28'b0, pending}, wq.size());
    for (int i = 0; i < 9; i++) begin
      transact("rdfill", 1'b0, 1'b0, 32'(i), $urandom, 1'b0);
    end

    // Range checks.
    transact("wt15", 1'b1, 1'b0, 32'd15, 32'h1515, 1'b1);
    rb = 32'd16;
    re = 32'd32;
    transact("err_rd32", 1'b0, 1'b0, 32'd32, $urandom, 1'b0);
    transact("err_wr15", 1'b1, 1'b0, 32'd15, 32'hBAD0, 1'b0);
    transact("ok_wr16", 1'b1, 1'b0, 32'd16, 32'h1616, 1'b1);
    transact("ok_rd31", 1'b0, 1'b0, 32'd31, $urandom, 1'b1);
    rb = 32'd0;
    re = 32'd2000;
    transact("err_ram1024", 1'b0, 1'b0, 32'd1024, $urandom, 1'b0);
    transact("ok_rd1023", 1'b0, 1'b0, 32'd1023, $urandom, 1'b0);
    transact("rd15", 1'b0, 1'b0, 32'd15, $urandom, 1'b1);

    // Read-through behind three posted writes.
    transact("pw101", 1'b1, 1'b0, 32'd101, 32'h0101, 1'b0);
    transact("pw100", 1'b1, 1'b0, 32'd100, 32'h0100, 1'b0);
    transact("pw102", 1'b1, 1'b0, 32'd102, 32'h0102, 1'b0);
    transact("rt100", 1'b0, 1'b0, 32'd100, $urandom, 1'b1);

    // Both strobes: the write wins.
    transact("both", 1'b1, 1'b1, 32'd103, 32'h0103, 1'b0);
    transact("rd103", 1'b0, 1'b0, 32'd103, $urandom, 1'b0);

    // Reset in the middle of a RAM read with posted writes outstanding.
    transact("pre_a", 1'b1, 1'b0, 32'd200, 32'h200, 1'b0);
    transact("pre_b", 1'b1, 1'b0, 32'd201, 32'h201, 1'b0);
    ptr          = 32'd202;
    w_en         = 1'b0;
    r_en         = 1'b1;
    read_through = 1'b0;
    while (avail !== 1'b1) @(negedge clock);
    @(posedge clock);
    #1;
    r_en = 1'b0;
    @(posedge clock);
    #2;
    check("mid.pending", {28'b0, pending}, wq.size());
    reset_n = 1'b0;
    #1;
    check("mid.avail", {31'b0, avail}, 32'd0);
    check("mid.done", {31'b0, done}, 32'd0);
    check("mid.data", data_load, 32'd0);
    check("mid.err", {31'b0, err}, 32'd0);
    check("mid.pending0", {28'b0, pending}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (done) seen = 1'b1;
    end
    check("mid.nodone", {31'b0, seen}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("mid.avail_rise", {31'b0, avail}, 32'd1);
    check("mid.done_after", {31'b0, done}, 32'd0);
    wq.delete();
    foreach (mem_valid[i]) mem_valid[i] = 1'b0;

    // Randomized traffic over a dense address set to exercise hits, duplicates and wrap.
    for (int k = 0; k < 400; k++) begin
      bit          wr;
      bit          both;
      bit          thr;
      logic [31:0] p;
      if ($urandom_range(0, 9) == 0) begin
        rb = 32'd1000;
        re = 32'd1100;
        p  = 32'($urandom_range(1016, 1030));
      end else begin
        rb = 32'($urandom_range(0, 8));
        re = 32'($urandom_range(40, 64));
        p  = 32'($urandom_range(0, 70));
      end
      wr   = 1'($urandom_range(0, 1));
      both = wr && ($urandom_range(0, 4) == 0);
      thr  = ($urandom_range(0, 5) == 0);
      idle($urandom_range(0, 3));
      transact("rnd", wr, both, p, $urandom, thr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
